// File: rtl/dcache_wb_axi.sv
// dcache_wb_axi: writes one dirty 32-byte dcache line back over AXI3 as an
// 8-beat INCR burst of 32-bit words (AW, then 8 W beats, then B).
// Optional build macro WB_LINE_BUFFER_EN: capture the line into a local
// buffer when the write-back starts, so the dcache may change wb_data_i
// afterwards. Without it, wdata is muxed straight from wb_data_i, and the
// dcache must hold the line stable until wb_done_o.

module dcache_wb_axi #(
    parameter logic [3:0] WB_ID = 4'h1
) (
    input  logic         aclk,
    input  logic         aresetn,
    // AXI write-address channel
    output logic [3:0]   awid,
    output logic [31:0]  awaddr,
    output logic [3:0]   awlen,
    output logic [2:0]   awsize,
    output logic [1:0]   awburst,
    output logic [1:0]   awlock,
    output logic [3:0]   awcache,
    output logic [2:0]   awprot,
    output logic         awvalid,
    input  logic         awready,
    // AXI write-data channel
    output logic [3:0]   wid,
    output logic [31:0]  wdata,
    output logic [3:0]   wstrb,
    output logic         wlast,
    output logic         wvalid,
    input  logic         wready,
    // AXI write-response channel
    input  logic [3:0]   bid,
    input  logic [1:0]   bresp,
    input  logic         bvalid,
    output logic         bready,
    // dcache side
    input  logic         wb_req_i,
    input  logic [31:0]  wb_addr_i,
    input  logic [255:0] wb_data_i,
    input  logic         icache_active,
    output logic         wb_busy_o,
    output logic         wb_done_o,
    output logic         wb_err_o
);

    // One-hot states:
    // IDLE   | waiting for a write-back request while icache is quiet
    // AW_REQ | presenting the line address on AW
    // W_XFER | streaming the 8 data beats
    // B_WAIT | waiting for the write response
    typedef enum logic [3:0] {
        IDLE   = 4'b0001,
        AW_REQ = 4'b0010,
        W_XFER = 4'b0100,
        B_WAIT = 4'b1000
    } state_t;

    state_t      state;
    state_t      state_next;
    logic        start;
    logic [2:0]  beat;
    logic [31:0] addr_q;

    // bid is not checked, and the low address bits are forced to a line boundary.
    logic unused_inputs;
    assign unused_inputs = ^{bid, wb_addr_i[4:0]};

    assign awid    = WB_ID;
    assign wid     = WB_ID;
    assign awlen   = 4'h7;
    assign awsize  = 3'b010;
    assign awburst = 2'b01;
    assign awlock  = 2'b00;
    assign awcache = 4'h0;
    assign awprot  = 3'b000;
    assign wstrb   = 4'hF;

    assign awaddr    = addr_q;
    assign wb_busy_o = (state != IDLE);
    assign wlast     = (state == W_XFER) && (beat == 3'd7);

    // State register.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state decode and per-state channel handshake outputs.
    always_comb begin
        state_next = state;
        start      = 1'b0;
        awvalid    = 1'b0;
        wvalid     = 1'b0;
        bready     = 1'b0;
        wb_done_o  = 1'b0;
        wb_err_o   = 1'b0;
        case (state)
            IDLE: begin
                if (wb_req_i && !icache_active) begin
                    start      = 1'b1;
                    state_next = AW_REQ;
                end
            end
            AW_REQ: begin
                awvalid = 1'b1;
                if (awready) begin
                    state_next = W_XFER;
                end
            end
            W_XFER: begin
                wvalid = 1'b1;
                if (wready && (beat == 3'd7)) begin
                    state_next = B_WAIT;
                end
            end
            B_WAIT: begin
                bready = 1'b1;
                if (bvalid) begin
                    wb_done_o  = 1'b1;
                    wb_err_o   = (bresp != 2'b00);
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Line address latched at request acceptance and held for the whole burst.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            addr_q <= '0;
        end else if (start) begin
            addr_q <= {wb_addr_i[31:5], 5'b0};
        end
    end

    // Beat counter advances only on an accepted beat; wrapping after beat 7
    // leaves it at 0 for the next burst.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            beat <= '0;
        end else if ((state == W_XFER) && wready) begin
            beat <= beat + 3'd1;
        end
    end

`ifdef WB_LINE_BUFFER_EN
    logic [255:0] line_buf;

    // Snapshot of the line taken when the write-back is accepted.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            line_buf <= '0;
        end else if (start) begin
            line_buf <= wb_data_i;
        end
    end

    assign wdata = line_buf[{beat, 5'b0} +: 32];
`else
    assign wdata = wb_data_i[{beat, 5'b0} +: 32];
`endif

endmodule

// File: tb/tb_dcache_wb_axi.sv
// tb_dcache_wb_axi: directed and randomized write-back bursts checked against
// a transaction-level expectation (line address, word order, last flag,
// completion cycle derived from the ready pattern the bench drives).

module tb_dcache_wb_axi;

    logic         aclk = 1'b0;
    logic         aresetn;
    logic [3:0]   awid;
    logic [31:0]  awaddr;
    logic [3:0]   awlen;
    logic [2:0]   awsize;
    logic [1:0]   awburst;
    logic [1:0]   awlock;
    logic [3:0]   awcache;
    logic [2:0]   awprot;
    logic         awvalid;
    logic         awready;
    logic [3:0]   wid;
    logic [31:0]  wdata;
    logic [3:0]   wstrb;
    logic         wlast;
    logic         wvalid;
    logic         wready;
    logic [3:0]   bid;
    logic [1:0]   bresp;
    logic         bvalid;
    logic         bready;
    logic         wb_req_i;
    logic [31:0]  wb_addr_i;
    logic [255:0] wb_data_i;
    logic         icache_active;
    logic         wb_busy_o;
    logic         wb_done_o;
    logic         wb_err_o;

    int n_checks = 0;
    int n_pass   = 0;
    int n_fail   = 0;

    always #5 aclk = ~aclk;

    dcache_wb_axi dut (
        .aclk          (aclk),
        .aresetn       (aresetn),
        .awid          (awid),
        .awaddr        (awaddr),
        .awlen         (awlen),
        .awsize        (awsize),
        .awburst       (awburst),
        .awlock        (awlock),
        .awcache       (awcache),
        .awprot        (awprot),
        .awvalid       (awvalid),
        .awready       (awready),
        .wid           (wid),
        .wdata         (wdata),
        .wstrb         (wstrb),
        .wlast         (wlast),
        .wvalid        (wvalid),
        .wready        (wready),
        .bid           (bid),
        .bresp         (bresp),
        .bvalid        (bvalid),
        .bready        (bready),
        .wb_req_i      (wb_req_i),
        .wb_addr_i     (wb_addr_i),
        .wb_data_i     (wb_data_i),
        .icache_active (icache_active),
        .wb_busy_o     (wb_busy_o),
        .wb_done_o     (wb_done_o),
        .wb_err_o      (wb_err_o)
    );

    task automatic chk(input string tag, input logic [255:0] got, input logic [255:0] exp);
        n_checks++;
        assert (got === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic idle_inputs();
        wb_req_i      = 1'b0;
        icache_active = 1'b0;
        awready       = 1'b0;
        wready        = 1'b0;
        bvalid        = 1'b0;
        bresp         = 2'b00;
        bid           = 4'h0;
    endtask

    // One write-back. The bench chooses every ready/valid it drives, so the
    // expected AW cycle and completion cycle follow from those choices alone.
    task automatic run_txn(input logic [31:0] addr, input logic [255:0] data,
                           input int aw_stall, input int w_mode, input logic [1:0] resp,
                           input int b_delay, input int icache_hold, input bit icache_rand,
                           input string tag);
        logic [31:0]  exp_addr;
        logic [31:0]  beats[$];
        logic         lasts[$];
        logic         wr_hist[256];
        logic [255:0] got_vec;
        logic [7:0]   last_vec;
        logic         err_seen;
        int aw_seen, b_seen, aw_hs, aw_hs_cyc, aw_bad, order_bad, busy_bad;
        int done_cnt, done_cyc, err_stray, exp_aw, exp_last, exp_done, cnt;
        bit fin;

        exp_addr = {addr[31:5], 5'b0};
        for (int i = 0; i < 256; i++) wr_hist[i] = 1'b0;
        aw_seen = 0; b_seen = 0; aw_hs = 0; aw_hs_cyc = -1; aw_bad = 0;
        order_bad = 0; busy_bad = 0; done_cnt = 0; done_cyc = -1; err_stray = 0;
        err_seen = 1'b0; fin = 1'b0;

        for (int cyc = 0; cyc < 200 && !fin; cyc++) begin
            @(negedge aclk);
            wb_req_i  = 1'b1;
            wb_addr_i = addr;
            wb_data_i = data;
            if (cyc < icache_hold)
                icache_active = 1'b1;
            else if (cyc > icache_hold && icache_rand)
                icache_active = 1'($urandom_range(0, 1));
            else
                icache_active = 1'b0;
            awready = (aw_seen >= aw_stall);
            case (w_mode)
                0:       wready = 1'b1;
                1:       wready = cyc[0];
                default: wready = 1'($urandom_range(0, 1));
            endcase
            wr_hist[cyc] = wready;
            bvalid = (b_seen >= b_delay);
            bresp  = bvalid ? resp : 2'b00;
            bid    = 4'($urandom_range(0, 15));
            #1;
            if (wb_busy_o !== (cyc > icache_hold)) busy_bad++;
            if (wvalid && aw_hs == 0) order_bad++;
            if (awvalid) begin
                if (awaddr !== exp_addr) aw_bad++;
                if (awready) begin
                    aw_hs++;
                    aw_hs_cyc = cyc;
                end else begin
                    aw_seen++;
                end
            end
            if (wvalid && wready) begin
                beats.push_back(wdata);
                lasts.push_back(wlast);
            end
            if (bready && !bvalid) b_seen++;
            if (wb_err_o && !wb_done_o) err_stray++;
            if (wb_done_o) begin
                done_cnt++;
                done_cyc = cyc;
                err_seen = wb_err_o;
            end
            if (wb_done_o || (bready && bvalid)) fin = 1'b1;
        end

        @(negedge aclk);
        idle_inputs();
        #1;
        chk({tag, " idle_after"}, 256'({wb_busy_o, wb_done_o, wb_err_o, awvalid, wvalid, bready}), 256'(0));

        exp_aw   = icache_hold + 1 + aw_stall;
        exp_last = -1;
        cnt      = 0;
        for (int c = exp_aw + 1; c < 256 && exp_last < 0; c++) begin
            if (wr_hist[c]) begin
                cnt++;
                if (cnt == 8) exp_last = c;
            end
        end
        exp_done = (exp_last < 0) ? 999 : exp_last + 1 + b_delay;

        got_vec  = '0;
        last_vec = '0;
        for (int i = 0; i < beats.size() && i < 8; i++) begin
            got_vec[32*i +: 32] = beats[i];
            last_vec[i]         = lasts[i];
        end

        chk({tag, " aw_handshakes"}, 256'(aw_hs), 256'(1));
        chk({tag, " aw_cycle"},      256'(aw_hs_cyc), 256'(exp_aw));
        chk({tag, " awaddr_bad"},    256'(aw_bad), 256'(0));
        chk({tag, " w_before_aw"},   256'(order_bad), 256'(0));
        chk({tag, " beat_count"},    256'(beats.size()), 256'(8));
        chk({tag, " beat_data"},     got_vec, data);
        chk({tag, " wlast_map"},     256'(last_vec), 256'(8'h80));
        chk({tag, " done_pulses"},   256'(done_cnt), 256'(1));
        chk({tag, " done_cycle"},    256'(done_cyc), 256'(exp_done));
        chk({tag, " err"},           256'({err_stray != 0, err_seen}), 256'({1'b0, resp != 2'b00}));
        chk({tag, " busy_bad"},      256'(busy_bad), 256'(0));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, observed timeout expected $finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [255:0] line;
        logic [31:0]  raddr;
        int           hs;
        int           stray;
        bit           got3;

        aresetn   = 1'b0;
        wb_addr_i = '0;
        wb_data_i = '0;
        idle_inputs();

        // Reset values and tie-offs.
        repeat (2) @(negedge aclk);
        #1;
        chk("reset_ctrl", 256'({awvalid, wvalid, bready, wlast, wb_busy_o, wb_done_o, wb_err_o}), 256'(0));
        chk("reset_awaddr", 256'(awaddr), 256'(0));
        chk("ids", 256'({awid, wid}), 256'(8'h11));
        chk("constants", 256'({awlen, awsize, awburst, awlock, awcache, awprot, wstrb}),
            256'({4'h7, 3'b010, 2'b01, 2'b00, 4'h0, 3'b000, 4'hF}));
        @(negedge aclk);
        aresetn = 1'b1;

        // Basic line: words 0..7, every ready high.
        for (int i = 0; i < 8; i++) line[32*i +: 32] = 32'(i);
        run_txn(32'h1FC0_0024, line, 0, 0, 2'b00, 0, 0, 1'b0, "basic");

        // AW stalled for 5 cycles.
        for (int i = 0; i < 8; i++) line[32*i +: 32] = 32'hA5A5_0000 + 32'(i);
        run_txn(32'h8000_105F, line, 5, 0, 2'b00, 0, 0, 1'b0, "aw_stall");

        // wready toggling every other cycle.
        for (int i = 0; i < 8; i++) line[32*i +: 32] = $urandom;
        run_txn(32'h0000_0040, line, 0, 1, 2'b00, 0, 0, 1'b0, "w_toggle");

        // SLVERR response.
        for (int i = 0; i < 8; i++) line[32*i +: 32] = $urandom;
        run_txn(32'h4444_4444, line, 0, 0, 2'b10, 0, 0, 1'b0, "slverr");

        // icache busy for 4 cycles while the request is pending.
        for (int i = 0; i < 8; i++) line[32*i +: 32] = $urandom;
        run_txn(32'hFFFF_FFE0, line, 0, 0, 2'b00, 0, 4, 1'b0, "icache_block");

        // Randomized bursts, icache toggling after acceptance.
        for (int t = 0; t < 6; t++) begin
            for (int i = 0; i < 8; i++) line[32*i +: 32] = $urandom;
            raddr = $urandom;
            run_txn(raddr, line, $urandom_range(0, 3), 2, 2'($urandom_range(0, 3)),
                    $urandom_range(0, 3), $urandom_range(0, 2), 1'b1, "rand");
        end

        // Reset in the middle of the burst, while beat 3 is on the bus.
        for (int i = 0; i < 8; i++) line[32*i +: 32] = 32'hC0DE_0000 + 32'(i);
        hs   = 0;
        got3 = 1'b0;
        for (int cyc = 0; cyc < 30 && !got3; cyc++) begin
            @(negedge aclk);
            wb_req_i  = 1'b1;
            wb_addr_i = 32'h1234_5678;
            wb_data_i = line;
            awready   = 1'b1;
            wready    = 1'b1;
            bvalid    = 1'b0;
            #1;
            if (wvalid && wready) hs++;
            if (hs == 3) got3 = 1'b1;
        end
        @(negedge aclk);
        #1;
        chk("rst_beat3_wdata", 256'(wdata), 256'(32'hC0DE_0003));
        aresetn = 1'b0;
        #1;
        chk("rst_mid_ctrl", 256'({awvalid, wvalid, bready, wlast, wb_busy_o, wb_done_o, wb_err_o}), 256'(0));
        chk("rst_mid_awaddr", 256'(awaddr), 256'(0));
        @(negedge aclk);
        idle_inputs();
        bvalid = 1'b1;
        @(negedge aclk);
        aresetn = 1'b1;
        stray = 0;
        for (int cyc = 0; cyc < 15; cyc++) begin
            @(negedge aclk);
            #1;
            if (wb_done_o || wb_err_o || wb_busy_o || awvalid || wvalid) stray++;
        end
        chk("rst_no_completion", 256'(stray), 256'(0));
        idle_inputs();

        for (int i = 0; i < 8; i++) line[32*i +: 32] = $urandom;
        run_txn(32'h2000_0000, line, 0, 0, 2'b00, 0, 0, 1'b0, "after_reset");

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
